// File: rtl/rst_seq_if.sv
// Reset sequencer bus: raw per-channel reset requests in, sequenced resets and
// release status out. The driver of src_rst_n uses master, the sequencer slave.
interface rst_seq_if #(
    parameter int unsigned N_CH = 4
) ();
    localparam int unsigned REL_W = $clog2(N_CH + 1);

    logic [N_CH-1:0]  src_rst_n;
    logic [N_CH-1:0]  dst_rst_n;
    logic [REL_W-1:0] rel_cnt;
    logic             all_done;

    modport master (
        output src_rst_n,
        input  dst_rst_n,
        input  rel_cnt,
        input  all_done
    );

    modport slave (
        input  src_rst_n,
        output dst_rst_n,
        output rel_cnt,
        output all_done
    );
endinterface

// File: rtl/rst_seq.sv
// Ordered reset sequencer. Each asynchronous active-low reset request is
// synchronised into dst_clk, then channels are released one at a time in index
// order, each only after its request has been stably deasserted for HOLD_CYCLES
// cycles. Re-asserting any released channel pulls it and every later channel
// back into reset and restarts the sequence from that channel.
module rst_seq #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic     dst_clk,
    input  logic     dst_rst,
    rst_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned REL_W = $clog2(N_CH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [REL_W-1:0] PTR_END  = REL_W'(N_CH);

    // Synchroniser chain, stage 0 samples the raw request.
    logic [N_CH-1:0] sync_q [DEPTH];
    logic [N_CH-1:0] req_s;

    // Sequencing state: ptr is the next channel to release (equals rel_cnt).
    logic [REL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Output registers, kept separate so outputs come straight from flops.
    logic [N_CH-1:0] dst_q, dst_d;
    logic            done_q, done_d;

    // Decode helpers.
    logic             reassert;
    logic [REL_W-1:0] first_low;
    logic             cur_req;

    assign req_s = sync_q[DEPTH-1];

    // Per-channel DEPTH-stage synchroniser, cleared by block reset.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.src_rst_n;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Find the lowest released channel whose request dropped, and the request
    // level of the channel currently being held off.
    always_comb begin
        reassert  = 1'b0;
        first_low = '0;
        cur_req   = 1'b0;
        // Descending scan so the smallest matching index wins.
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if ((REL_W'(k) < ptr_q) && !req_s[k]) begin
                reassert  = 1'b1;
                first_low = REL_W'(k);
            end
        end
        for (int k = 0; k < int'(N_CH); k++) begin
            if (REL_W'(k) == ptr_q) begin
                cur_req = req_s[k];
            end
        end
    end

    // Next-state for pointer, hold counter and the outputs derived from them.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (reassert) begin
            // Re-assertion beats any release due in the same cycle.
            ptr_d = first_low;
            cnt_d = '0;
        end else if (ptr_q < PTR_END) begin
            if (cur_req) begin
                if (cnt_q == CNT_LAST) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                // Request still asserted (or glitched): restart the hold.
                cnt_d = '0;
            end
        end else begin
            cnt_d = '0;
        end

        dst_d = '0;
        for (int j = 0; j < int'(N_CH); j++) begin
            dst_d[j] = (REL_W'(j) < ptr_d);
        end
        done_d = (ptr_d == PTR_END);
    end

    // Sequencing and output registers with synchronous block reset.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            dst_q  <= '0;
            done_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            dst_q  <= dst_d;
            done_q <= done_d;
        end
    end

    assign bus.dst_rst_n = dst_q;
    assign bus.rel_cnt   = ptr_q;
    assign bus.all_done  = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: main instance N_CH=3, DEPTH=2, HOLD_CYCLES=4,
// plus a single-channel instance with HOLD_CYCLES=1.
module tb_rst_seq;
    logic clk = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    rst_seq_if #(.N_CH(3)) bus ();
    rst_seq_if #(.N_CH(1)) bus1 ();

    rst_seq #(.N_CH(3), .DEPTH(2), .HOLD_CYCLES(4)) dut (
        .dst_clk (clk),
        .dst_rst (rst),
        .bus     (bus)
    );

    rst_seq #(.N_CH(1), .DEPTH(2), .HOLD_CYCLES(1)) dut1 (
        .dst_clk (clk),
        .dst_rst (rst1),
        .bus     (bus1)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // {dst_rst_n[2:0], rel_cnt[1:0], all_done}
    logic [5:0] obs, exp_v;

    localparam logic [5:0] S0 = {3'b000, 2'd0, 1'b0};
    localparam logic [5:0] S1 = {3'b001, 2'd1, 1'b0};
    localparam logic [5:0] S2 = {3'b011, 2'd2, 1'b0};
    localparam logic [5:0] S3 = {3'b111, 2'd3, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held for two edges; the second is edge 0 of the sequence.
    task automatic start_seq(input logic [2:0] src);
        rst = 1'b1;
        bus.src_rst_n = src;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.src_rst_n = 3'b111;
        tick();
        tick();
        tick();
        obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
        n_chk++;
        if (obs !== S0) $display("FAIL reset outputs got %b want %b", obs, S0);
        else n_pass++;
        n_chk++;
        if (dut.cnt_q !== 3'd0) $display("FAIL reset cnt got %0d want 0", dut.cnt_q);
        else n_pass++;
    endtask

    task automatic test_release();
        start_seq(3'b111);
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_v = (e < 6) ? S0 : (e < 10) ? S1 : (e < 14) ? S2 : S3;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL release edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
    endtask

    // Continues from the all-released state left by test_release.
    task automatic test_reassert();
        bus.src_rst_n = 3'b101;
        for (int e = 1; e <= 3; e++) begin
            tick();
            exp_v = (e < 3) ? S3 : S1;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL reassert edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
        bus.src_rst_n = 3'b111;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_v = (e < 6) ? S1 : (e < 10) ? S2 : S3;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL rerelease edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_hold_off();
        start_seq(3'b011);
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_v = (e < 6) ? S0 : (e < 10) ? S1 : S2;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL holdoff edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
        n_chk++;
        if (dut.cnt_q !== 3'd0) $display("FAIL holdoff cnt got %0d want 0", dut.cnt_q);
        else n_pass++;
        bus.src_rst_n = 3'b111;
        for (int e = 1; e <= 6; e++) begin
            tick();
            exp_v = (e < 6) ? S2 : S3;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL late_release edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
    endtask

    // Channel 0 request drops so req_s[0] is low in the cycle channel 2 would release.
    task automatic test_collision();
        start_seq(3'b111);
        repeat (11) tick();
        bus.src_rst_n = 3'b110;
        for (int e = 12; e <= 14; e++) begin
            tick();
            exp_v = (e < 14) ? S2 : S0;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL collision edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
        bus.src_rst_n = 3'b111;
    endtask

    task automatic test_mid_reset();
        start_seq(3'b111);
        repeat (11) tick();
        obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
        n_chk++;
        if (obs !== S2) $display("FAIL midreset pre got %b want %b", obs, S2);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
        n_chk++;
        if (obs !== S0) $display("FAIL midreset pulse got %b want %b", obs, S0);
        else n_pass++;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_v = (e < 6) ? S0 : (e < 10) ? S1 : (e < 14) ? S2 : S3;
            obs = {bus.dst_rst_n, bus.rel_cnt, bus.all_done};
            n_chk++;
            if (obs !== exp_v) $display("FAIL midreset edge %0d got %b want %b", e, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [2:0] o1, e1;
        rst1 = 1'b1;
        bus1.src_rst_n = 1'b1;
        tick();
        tick();
        rst1 = 1'b0;
        o1 = {bus1.dst_rst_n, bus1.rel_cnt, bus1.all_done};
        n_chk++;
        if (o1 !== 3'b000) $display("FAIL single reset got %b want 000", o1);
        else n_pass++;
        for (int e = 1; e <= 4; e++) begin
            tick();
            e1 = (e < 3) ? 3'b000 : 3'b111;
            o1 = {bus1.dst_rst_n, bus1.rel_cnt, bus1.all_done};
            n_chk++;
            if (o1 !== e1) $display("FAIL single edge %0d got %b want %b", e, o1, e1);
            else n_pass++;
        end
    endtask

    initial begin
        bus.src_rst_n  = 3'b111;
        bus1.src_rst_n = 1'b1;
        test_reset();
        test_release();
        test_reassert();
        test_hold_off();
        test_collision();
        test_mid_reset();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter N_CH, default 4, number of reset channels; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 2, synchronizer flop stages per channel; SHALL be >= 2.
REQ-003 Parameter HOLD_CYCLES, default 16, dst_clk cycles each channel's request must be stable-deasserted before release; SHALL be >= 1.
REQ-004 Derived CNT_W = $clog2(HOLD_CYCLES+1); REL_W = $clog2(N_CH+1).
REQ-005 dst_clk  in  1  single block clock; all state in this domain.
REQ-006 dst_rst  in  1  block reset, synchronous to dst_clk, active-high.
REQ-007 src_rst_n  in  N_CH  per-channel reset requests, active-low, asynchronous to dst_clk.
REQ-008 dst_rst_n  out  N_CH  sequenced per-channel resets, active-low, registered, synchronous to dst_clk.
REQ-009 rel_cnt  out  REL_W  number of channels currently released (0..N_CH), registered.
REQ-010 all_done  out  1  high iff rel_cnt == N_CH, registered.

Function
REQ-011 Each src_rst_n[i] SHALL pass through its own DEPTH-stage flop chain clocked by dst_clk, giving req_s[i]; no logic between stages.
REQ-012 Release order SHALL be fixed: channel 0 first, then 1, ..., N_CH-1; channel k released only when channels 0..k-1 are released.
REQ-013 State: pointer ptr (= rel_cnt, next channel to release) and hold counter cnt (CNT_W bits); no other sequencing state.
REQ-014 While ptr < N_CH and req_s[ptr] == 1: cnt SHALL increment each cycle; in the cycle where cnt == HOLD_CYCLES-1, the next edge sets dst_rst_n[ptr]=1, ptr=ptr+1, cnt=0.
REQ-015 While ptr < N_CH and req_s[ptr] == 0: cnt SHALL be forced to 0 next edge (restart hold).
REQ-016 When ptr == N_CH: cnt held at 0, all_done=1, no further action unless REQ-017 fires.
REQ-017 Re-assertion: if req_s[k] == 0 for any k < ptr, with m = smallest such k, the next edge SHALL set dst_rst_n[j]=0 for all j >= m, ptr=m, cnt=0, all_done=0.
REQ-018 REQ-017 SHALL take priority over a release (REQ-014) in the same cycle.
REQ-019 Release latency: with all src_rst_n high and stable, dst_rst_n[0] rises on edge DEPTH+HOLD_CYCLES after leaving reset, and each subsequent channel HOLD_CYCLES edges after its predecessor.
REQ-020 Assertion latency: src_rst_n[k] falling (stable) SHALL drive dst_rst_n[k..N_CH-1] low DEPTH+1 edges later.
REQ-021 all_done SHALL rise on the same edge as dst_rst_n[N_CH-1] rises.
REQ-022 Outputs SHALL only change on dst_clk rising edges; no combinational path from src_rst_n to any output.
REQ-023 cnt SHALL never exceed HOLD_CYCLES-1; no wrap-around.

Reset
REQ-024 While dst_rst=1 at an edge: all synchronizer flops=0, dst_rst_n='0, ptr=0, cnt=0, rel_cnt=0, all_done=0.
REQ-025 dst_rst asserted mid-sequence or after all_done SHALL apply REQ-024 at the next edge regardless of src_rst_n; sequencing restarts from channel 0 after dst_rst deasserts.

Verification (N_CH=3, DEPTH=2, HOLD_CYCLES=4 unless stated)
REQ-026 dst_rst 1->0 at edge 0, src_rst_n=3'b111 -> dst_rst_n[0] rises edge 6, [1] edge 10, [2] edge 14; all_done and rel_cnt=3 at edge 14.
REQ-027 After all_done, src_rst_n[1]=0 held -> dst_rst_n=3'b001, rel_cnt=1 at +3 edges; src_rst_n[1]=1 again -> [1] rises +6 edges later, [2] +4 after that.
REQ-028 src_rst_n=3'b011 held -> sequence stops at rel_cnt=2, dst_rst_n=3'b011, cnt stays 0; raising src_rst_n[2] -> release after DEPTH+HOLD_CYCLES=6 edges.
REQ-029 Collision: req_s[0] falls in the cycle channel 2 would release -> next edge dst_rst_n=3'b000, rel_cnt=0, all_done=0.
REQ-030 dst_rst pulsed 1 cycle with rel_cnt=2 -> next edge all outputs 0; re-release follows REQ-026 timing from the deassert edge.
REQ-031 N_CH=1, HOLD_CYCLES=1: src_rst_n high -> dst_rst_n and all_done rise at edge DEPTH+1=3.
